disp_share_arb: RTL and testbench

Arbiter that shares the single 4-digit 7-segment display path (digit mux plus hex decoder) between up to four 16-bit value sources, e.g. the free-running counter, a stopwatch, and a debug register.
- Grants the display to one requester at a time, round-robin.
- Each grant is held for a minimum number of slow enable ticks so a value stays readable before another source takes over.
- Output drives the 16-bit value feeding the four digit nibbles, plus a blank flag.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/disp_share_arb.sv | 137 +++++++++++++
 tb/tb_disp_share_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared constants for the 7-segment display sharing logic:
//                arbiter state encoding, digit geometry and a pointer-width
//                helper used by the round-robin selector and the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Arbiter state encoding
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_OWN  = 1'b1;

    // Display geometry: four digits of one hex nibble each
    localparam int c_DIGITS = 4;
    localparam int c_NIBBLE = 4;
    localparam int c_DW     = c_DIGITS * c_NIBBLE;

    // Width of a requester index for 2..4 requesters
    function automatic int ptr_w(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first
//                request bit not in the exclude mask, scanning upward from
//                the start index and wrapping modulo NREQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   start,
    input  logic [NREQ-1:0] excl,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    logic [NREQ-1:0] w_masked;
    int              w_dist;
    int              w_best;

    assign w_masked = req & ~excl;

    // Pick the eligible requester with the smallest forward distance from start
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_best = NREQ;
        w_dist = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j + NREQ - int'(start)) % NREQ;
            if (w_masked[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                valid  = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/disp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : disp_share_arb
//  Description : Round-robin arbiter sharing the 4-digit 7-segment display
//                path between up to four value sources. A grant is held for
//                at least HOLD_TICKS slow ticks before another requester may
//                take over; voluntary release is always immediate.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_share_arb
    import disp_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = c_DW,
    parameter int HOLD_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] src_data,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      disp_data,
    output logic               disp_blank,
    output logic               hold_done
);

    localparam int         c_PW   = ptr_w(NREQ);
    localparam logic [3:0] c_HOLD = 4'(HOLD_TICKS);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(NREQ - 1);

    logic [0:0]      r_state;
    logic [c_PW-1:0] r_owner;
    logic [c_PW-1:0] r_rr_ptr;
    logic [3:0]      r_hold_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [DW-1:0]   r_disp_data;
    logic            r_disp_blank;
    logic            r_hold_done;

    logic [DW-1:0]   w_src [NREQ];
    logic [c_PW-1:0] w_own_next;
    logic [c_PW-1:0] w_start;
    logic [NREQ-1:0] w_excl;
    logic            w_pick_valid;
    logic [c_PW-1:0] w_pick_idx;
    logic [c_PW-1:0] w_pick_next;
    logic [NREQ-1:0] w_pick_oh;
    logic [3:0]      w_hold_inc;

    // Unpack the source bus so the owner index can select a value directly
    for (genvar i = 0; i < NREQ; i++) begin : g_src
        assign w_src[i] = src_data[i*DW +: DW];
    end

    assign w_own_next  = (r_owner == c_LAST) ? '0 : r_owner + 1'b1;
    assign w_pick_next = (w_pick_idx == c_LAST) ? '0 : w_pick_idx + 1'b1;
    assign w_pick_oh   = NREQ'(1) << w_pick_idx;
    assign w_hold_inc  = (tick && (r_hold_cnt != c_HOLD)) ? r_hold_cnt + 4'd1 : r_hold_cnt;

    // From IDLE scan from the saved pointer; while owning, scan past the owner
    assign w_start = (r_state == c_IDLE) ? r_rr_ptr : w_own_next;
    assign w_excl  = (r_state == c_IDLE) ? '0 : r_gnt;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_rr_pick (
        .req   (req),
        .start (w_start),
        .excl  (w_excl),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Grant FSM, hold counter and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
            r_gnt        <= '0;
            r_disp_data  <= '0;
            r_disp_blank <= 1'b1;
            r_hold_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pick_valid) begin
                        r_state      <= c_OWN;
                        r_owner      <= w_pick_idx;
                        r_gnt        <= w_pick_oh;
                        r_rr_ptr     <= w_pick_next;
                        r_hold_cnt   <= '0;
                        r_hold_done  <= 1'b0;
                        r_disp_blank <= 1'b0;
                    end
                end
                c_OWN: begin
                    if (!req[r_owner]) begin
                        // Voluntary release wins over any pending handover
                        r_state      <= c_IDLE;
                        r_gnt        <= '0;
                        r_rr_ptr     <= w_own_next;
                        r_hold_cnt   <= '0;
                        r_hold_done  <= 1'b0;
                        r_disp_blank <= 1'b1;
                        r_disp_data  <= '0;
                    end else if (r_hold_done && w_pick_valid) begin
                        // Direct handover, no blank cycle in between
                        r_owner      <= w_pick_idx;
                        r_gnt        <= w_pick_oh;
                        r_rr_ptr     <= w_pick_next;
                        r_hold_cnt   <= '0;
                        r_hold_done  <= 1'b0;
                        r_disp_data  <= w_src[r_owner];
                    end else begin
                        r_hold_cnt   <= w_hold_inc;
                        r_hold_done  <= (w_hold_inc == c_HOLD);
                        r_disp_data  <= w_src[r_owner];
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign disp_data  = r_disp_data;
    assign disp_blank = r_disp_blank;
    assign hold_done  = r_hold_done;

endmodule : disp_share_arb
`default_nettype wire

// File: tb/tb_disp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_share_arb
//  Description : Directed self-checking bench for disp_share_arb with
//                NREQ=4, DW=16, HOLD_TICKS=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_share_arb;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic               clk;
    logic               rst;
    logic               tick;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] src_data;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      disp_data;
    logic               disp_blank;
    logic               hold_done;

    int n_checks = 0;
    int n_errors = 0;

    disp_share_arb #(
        .NREQ       (NREQ),
        .DW         (DW),
        .HOLD_TICKS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .req        (req),
        .src_data   (src_data),
        .gnt        (gnt),
        .disp_data  (disp_data),
        .disp_blank (disp_blank),
        .hold_done  (hold_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, check invariants
    task automatic step();
        @(posedge clk);
        #1;
        check_eq("blank_inv", 32'(disp_blank), 32'(gnt == '0));
        check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] v);
        src_data[i*DW +: DW] = v;
    endtask

    function automatic logic [DW-1:0] src_of(input int i);
        return src_data[i*DW +: DW];
    endfunction

    initial begin
        int cur;
        int nxt;
        rst      = 1'b1;
        tick     = 1'b0;
        req      = '0;
        src_data = '0;
        step();
        step();
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_blank", 32'(disp_blank), 32'h1);
        check_eq("rst_data", 32'(disp_data), 32'h0);
        check_eq("rst_hold", 32'(hold_done), 32'h0);
        rst = 1'b0;

        // Idle with no requests
        for (int c = 0; c < 100; c++) begin
            step();
            check_eq("idle_gnt", 32'(gnt), 32'h0);
            check_eq("idle_data", 32'(disp_data), 32'h0);
        end

        // Single requester, data tracking
        set_src(1, 16'hBEEF);
        req = 4'b0010;
        step();
        check_eq("g1_gnt", 32'(gnt), 32'h2);
        check_eq("g1_blank", 32'(disp_blank), 32'h0);
        check_eq("g1_data0", 32'(disp_data), 32'h0);
        step();
        check_eq("g1_data", 32'(disp_data), 32'hBEEF);
        set_src(1, 16'h1234);
        step();
        check_eq("g1_track", 32'(disp_data), 32'h1234);

        // Two requesters, hold enforced then rotate 1 -> 0 -> 1 -> 0
        req = 4'b0011;
        for (int r = 0; r < 3; r++) begin
            cur = (r % 2 == 0) ? 1 : 0;
            nxt = 1 - cur;
            for (int p = 1; p <= 4; p++) begin
                pulse();
                check_eq("hold2_gnt", 32'(gnt), 32'(1 << cur));
                check_eq("hold2_done", 32'(hold_done), 32'(p == 4));
            end
            step();
            check_eq("sw2_gnt", 32'(gnt), 32'(1 << nxt));
            check_eq("sw2_done", 32'(hold_done), 32'h0);
        end

        // All four requesting: order 0,1,2,3,0
        set_src(0, 16'hA000);
        set_src(1, 16'hA111);
        set_src(2, 16'hA222);
        set_src(3, 16'hA333);
        req = 4'b1111;
        cur = 0;
        for (int n = 0; n < 4; n++) begin
            nxt = (cur + 1) % NREQ;
            for (int p = 1; p <= 4; p++) begin
                pulse();
                check_eq("rr4_gnt", 32'(gnt), 32'(1 << cur));
                check_eq("rr4_done", 32'(hold_done), 32'(p == 4));
                if (p == 1) check_eq("rr4_data", 32'(disp_data), 32'(src_of(cur)));
            end
            step();
            check_eq("rr4_next", 32'(gnt), 32'(1 << nxt));
            check_eq("rr4_blank", 32'(disp_blank), 32'h0);
            cur = nxt;
        end

        // Owner 2 releases early, rr pointer wraps to 0
        req = 4'b0101;
        for (int p = 0; p < 4; p++) pulse();
        step();
        check_eq("o2_gnt", 32'(gnt), 32'h4);
        pulse();
        req = 4'b0001;
        step();
        check_eq("rel_gnt", 32'(gnt), 32'h0);
        check_eq("rel_blank", 32'(disp_blank), 32'h1);
        check_eq("rel_data", 32'(disp_data), 32'h0);
        check_eq("rel_done", 32'(hold_done), 32'h0);
        step();
        check_eq("wrap_gnt", 32'(gnt), 32'h1);

        // Reset mid-grant with hold_cnt=2
        req = 4'b0101;
        for (int p = 0; p < 4; p++) pulse();
        step();
        check_eq("pre_rst_gnt", 32'(gnt), 32'h4);
        pulse();
        pulse();
        rst = 1'b1;
        step();
        check_eq("mrst_gnt", 32'(gnt), 32'h0);
        check_eq("mrst_blank", 32'(disp_blank), 32'h1);
        check_eq("mrst_done", 32'(hold_done), 32'h0);
        rst = 1'b0;
        req = 4'b0100;
        step();
        check_eq("post_rst_gnt", 32'(gnt), 32'h4);
        req = 4'b0101;
        for (int p = 1; p <= 4; p++) begin
            pulse();
            check_eq("post_rst_hgnt", 32'(gnt), 32'h4);
            check_eq("post_rst_done", 32'(hold_done), 32'(p == 4));
        end

        // Release coinciding with expired hold: release wins, grant via IDLE
        req = 4'b0001;
        step();
        check_eq("relwin_gnt", 32'(gnt), 32'h0);
        check_eq("relwin_blank", 32'(disp_blank), 32'h1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_eq("relwin_next", 32'(gnt), 32'h1);
        check_eq("tick_ign_done", 32'(hold_done), 32'h0);
        for (int p = 1; p <= 4; p++) begin
            pulse();
            check_eq("solo_done", 32'(hold_done), 32'(p == 4));
        end

        // Sole requester keeps the grant indefinitely with hold saturated
        for (int p = 0; p < 3; p++) begin
            pulse();
            step();
            check_eq("solo_gnt", 32'(gnt), 32'h1);
            check_eq("solo_sat", 32'(hold_done), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_disp_share_arb
`default_nettype wire
